// File: rtl/spi_peek_pkg.sv
// spi_peek_pkg: shared definitions for the spi_peek_regs SPI register slave.
//   state_e        : transaction state (idle, command byte, data words, ignore)
//   CMD_BITS       : length of the command byte
//   ADDR_BITS      : width of the address field in the command byte
//   WRITE_BIT      : position of the write flag in the command byte
//   sample_on_rise : true when the SCLK rising edge is the sample edge
package spi_peek_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_CMD    = 2'd1,
      ST_DATA   = 2'd2,
      ST_IGNORE = 2'd3
   } state_e;

   localparam int unsigned CMD_BITS  = 8;
   localparam int unsigned ADDR_BITS = 7;
   localparam int unsigned WRITE_BIT = 7;

   // Leading edge is rising for CPOL=0; CPHA=1 moves sampling to the trailing
   // edge. Both flips cancel, so sampling is on the rising edge when CPOL==CPHA.
   function automatic logic sample_on_rise(input int cpol, input int cpha);
      return (cpol == cpha);
   endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: 3-flop synchroniser for an asynchronous input with one-clock
// edge pulses derived from the top two flops.
//   clk  : fabric clock
//   din  : asynchronous input
//   rise : one-clock pulse after a 0->1 transition of din
//   fall : one-clock pulse after a 1->0 transition of din
module spi_sync_edge (
   input  logic clk,
   input  logic din,
   output logic rise,
   output logic fall
);

   logic [2:0] sh_q;
   logic [2:0] sh_d;

   always_comb begin
      sh_d = {sh_q[1:0], din};
   end

   // Not reset: the chain keeps following the pin during reset so that a line
   // already low at reset release does not look like a fresh falling edge.
   always_ff @(posedge clk) begin
      sh_q <= sh_d;
   end

   assign rise =  sh_q[1] & ~sh_q[2];
   assign fall = ~sh_q[1] &  sh_q[2];

endmodule

// File: rtl/spi_peek_regs.sv
// spi_peek_regs: SPI slave giving a microcontroller addressed peek/poke access
// to NREGS words of WIDTH bits. Each transaction is a command byte
// (bit7 = write, bits[6:0] = address) followed by one data word, MSB first.
// Optional feature macro SPI_PEEK_REGS_AUTOINC_EN: a transaction may carry
// consecutive data words with the address incrementing after each word.
//   clk, rst_    : fabric clock, synchronous active-low reset
//   ucSCLK/ucMOSI/ucSEL_ : asynchronous SPI inputs from the microcontroller
//   ucMISO, ucMISO_oe    : SPI data out and its tri-state enable
//   peek_data    : NREGS packed read words (word i at [i*WIDTH +: WIDTH])
//   poke_data    : NREGS packed registered write words, same packing
//   poke_strobe  : one-clock pulse per word written
//   busy         : high while the slave is selected
module spi_peek_regs
   import spi_peek_pkg::*;
#(
   parameter int unsigned      WIDTH     = 32,
   parameter int unsigned      NREGS     = 4,
   parameter int unsigned      CPOL      = 0,
   parameter int unsigned      CPHA      = 0,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic                   clk,
   input  logic                   rst_,
   input  logic                   ucSCLK,
   input  logic                   ucMOSI,
   input  logic                   ucSEL_,
   output logic                   ucMISO,
   output logic                   ucMISO_oe,
   input  logic [NREGS*WIDTH-1:0] peek_data,
   output logic [NREGS*WIDTH-1:0] poke_data,
   output logic [NREGS-1:0]       poke_strobe,
   output logic                   busy
);

   localparam logic       SAMPLE_RISE = sample_on_rise(CPOL, CPHA);
   localparam logic [7:0] NREGS_L     = 8'(NREGS);

   logic sclk_rise, sclk_fall, sel_rise, sel_fall;
   logic [1:0] mosi_q, mosi_d;
   logic mosi_s, sample_edge, shift_edge;

   spi_sync_edge u_sclk_sync (.clk(clk), .din(ucSCLK), .rise(sclk_rise), .fall(sclk_fall));
   spi_sync_edge u_sel_sync  (.clk(clk), .din(ucSEL_), .rise(sel_rise),  .fall(sel_fall));

   always_comb begin
      mosi_d = {mosi_q[0], ucMOSI};
   end

   always_ff @(posedge clk) begin
      mosi_q <= mosi_d;
   end

   assign mosi_s      = mosi_q[1];
   assign sample_edge = SAMPLE_RISE ? sclk_rise : sclk_fall;
   assign shift_edge  = SAMPLE_RISE ? sclk_fall : sclk_rise;

   state_e                  state_q, state_d;
   logic [6:0]              bit_cnt_q, bit_cnt_d;
   logic [WIDTH-2:0]        rx_q, rx_d;
   logic [WIDTH-1:0]        tx_q, tx_d;
   logic                    wr_q, wr_d;
   logic [ADDR_BITS-1:0]    addr_q, addr_d;
   logic [NREGS*WIDTH-1:0]  poke_q, poke_d;
   logic [NREGS-1:0]        strobe_q, strobe_d;
   logic                    busy_q, busy_d;
   logic                    oe_q, oe_d;
   logic                    skip_q, skip_d;

   logic [CMD_BITS-1:0]     cmd;
   logic [ADDR_BITS-1:0]    ld_addr;
   logic [WIDTH-1:0]        peek_ld;

   assign cmd     = {rx_q[CMD_BITS-2:0], mosi_s};
   assign ld_addr = (state_q == ST_CMD) ? cmd[ADDR_BITS-1:0] : addr_q + 7'd1;

   always_comb begin
      peek_ld = '0;
      for (int unsigned i = 0; i < NREGS; i++) begin
         if (ld_addr == 7'(i)) peek_ld = peek_data[i*WIDTH +: WIDTH];
      end
   end

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      rx_d      = rx_q;
      tx_d      = tx_q;
      wr_d      = wr_q;
      addr_d    = addr_q;
      poke_d    = poke_q;
      strobe_d  = '0;
      busy_d    = busy_q;
      oe_d      = oe_q;
      skip_d    = skip_q;

      // Every tx load is followed by one suppressed shift edge so the freshly
      // loaded MSB is held until the master samples it. The load at select
      // start only needs this for CPHA=1, where a leading edge precedes the
      // first sample.
      if ((state_q == ST_CMD || state_q == ST_DATA) && shift_edge) begin
         if (skip_q) skip_d = 1'b0;
         else        tx_d   = {tx_q[WIDTH-2:0], 1'b0};
      end

      case (state_q)
         ST_IDLE: begin
            if (sel_fall) begin
               state_d   = ST_CMD;
               bit_cnt_d = '0;
               tx_d      = '0;
               skip_d    = (CPHA != 0);
               busy_d    = 1'b1;
               oe_d      = 1'b1;
            end
         end
         ST_CMD: begin
            if (sample_edge) begin
               rx_d      = {rx_q[WIDTH-3:0], mosi_s};
               bit_cnt_d = bit_cnt_q + 7'd1;
               if (bit_cnt_q == 7'(CMD_BITS - 1)) begin
                  bit_cnt_d = '0;
                  wr_d      = cmd[WRITE_BIT];
                  addr_d    = cmd[ADDR_BITS-1:0];
                  if ({1'b0, cmd[ADDR_BITS-1:0]} < NREGS_L) begin
                     state_d = ST_DATA;
                     tx_d    = peek_ld;
                     skip_d  = 1'b1;
                  end else begin
                     state_d = ST_IGNORE;
                  end
               end
            end
         end
         ST_DATA: begin
            if (sample_edge) begin
               rx_d      = {rx_q[WIDTH-3:0], mosi_s};
               bit_cnt_d = bit_cnt_q + 7'd1;
               if (bit_cnt_q == 7'(WIDTH - 1)) begin
                  bit_cnt_d = '0;
                  if (wr_q) begin
                     for (int unsigned i = 0; i < NREGS; i++) begin
                        if (addr_q == 7'(i)) begin
                           poke_d[i*WIDTH +: WIDTH] = {rx_q, mosi_s};
                           strobe_d[i]              = 1'b1;
                        end
                     end
                  end
`ifdef SPI_PEEK_REGS_AUTOINC_EN
                  if (({1'b0, addr_q} + 8'd1) < NREGS_L) begin
                     addr_d = addr_q + 7'd1;
                     tx_d   = peek_ld;
                     skip_d = 1'b1;
                  end else begin
                     state_d = ST_IGNORE;
                  end
`else
                  state_d = ST_IGNORE;
`endif
               end
            end
         end
         ST_IGNORE: ;
         default: state_d = ST_IDLE;
      endcase

      // Deselect wins over the state update but not over a write completed
      // by a sample edge seen in the same clock.
      if (sel_rise) begin
         state_d = ST_IDLE;
         busy_d  = 1'b0;
         oe_d    = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_) begin
         state_q   <= ST_IDLE;
         bit_cnt_q <= '0;
         rx_q      <= '0;
         tx_q      <= '0;
         wr_q      <= 1'b0;
         addr_q    <= '0;
         poke_q    <= {NREGS{RESET_VAL}};
         strobe_q  <= '0;
         busy_q    <= 1'b0;
         oe_q      <= 1'b0;
         skip_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         rx_q      <= rx_d;
         tx_q      <= tx_d;
         wr_q      <= wr_d;
         addr_q    <= addr_d;
         poke_q    <= poke_d;
         strobe_q  <= strobe_d;
         busy_q    <= busy_d;
         oe_q      <= oe_d;
         skip_q    <= skip_d;
      end
   end

   assign ucMISO      = (state_q == ST_CMD || state_q == ST_DATA) ? tx_q[WIDTH-1] : 1'b0;
   assign ucMISO_oe   = oe_q;
   assign busy        = busy_q;
   assign poke_data   = poke_q;
   assign poke_strobe = strobe_q;

endmodule
